sra_share_arbiter: RTL

//  Shares one combinational arithmetic-right-shift barrel shifter (C = A >>> B, sign-filled)

---
 rtl/sra_share_arbiter_if.sv | 35 +++
 rtl/sra_share_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sra_share_arbiter_if.sv
// rtl/sra_share_arbiter_if.sv - request/result bundle for the shared arithmetic-right-shift unit
interface sra_share_arbiter_if #(
  parameter int N = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         res_valid;
  logic         res_ready;
  logic         res_id;
  logic [N-1:0] res_data;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  res_valid, res_id, res_data,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output res_valid, res_id, res_data,
    input  res_ready
  );
endinterface

// File: rtl/sra_share_arbiter.sv
// rtl/sra_share_arbiter.sv - round-robin sharing of one registered arithmetic-right-shift unit
module sra_share_arbiter #(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst,
  sra_share_arbiter_if.slave bus
);
  localparam int LGN = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  logic         id_r;
  logic         rr_last;
  logic [N-1:0] res_data_r;
  logic         res_id_r;

  logic         grant_valid;
  logic         grant_id;
  logic         accept;
  logic         ready0;
  logic         ready1;
  logic         res_valid_c;

  logic               overshift;
  logic signed [N-1:0] a_signed;
  logic signed [N-1:0] a_shifted;
  logic [N-1:0]       shift_res;

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~rr_last;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ready0      = 1'b0;
    ready1      = 1'b0;
    res_valid_c = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          accept    = 1'b1;
          ready0    = ~grant_id;
          ready1    = grant_id;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        state_nxt = DONE;
      end
      DONE: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Any set bit above the low LGN bits shifts every data bit out, leaving only sign fill.
  assign overshift = |b_r[N-1:LGN];
  assign a_signed  = a_r;
  assign a_shifted = a_signed >>> b_r[LGN-1:0];
  assign shift_res = overshift ? {N{a_r[N-1]}} : a_shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= '0;
      b_r        <= '0;
      id_r       <= 1'b0;
      rr_last    <= 1'b1;
      res_data_r <= '0;
      res_id_r   <= 1'b0;
    end else begin
      if (accept) begin
        a_r     <= grant_id ? bus.req1_a : bus.req0_a;
        b_r     <= grant_id ? bus.req1_b : bus.req0_b;
        id_r    <= grant_id;
        rr_last <= grant_id;
      end
      if (state == SHIFT) begin
        res_data_r <= shift_res;
        res_id_r   <= id_r;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = res_valid_c;
  assign bus.res_data   = res_data_r;
  assign bus.res_id     = res_id_r;
endmodule
